// File: rtl/fb_cu_pipe.sv
// Pipelined control unit: decodes the ID opcode and carries the control bits through
// ID/EX, EX/MEM and MEM/WB, applying stall/flush bubbles and multi-cycle load waits.
module fb_cu_pipe #(
    parameter int unsigned ALU_OP_W      = 2,
    parameter int unsigned LOAD_LAT      = 1,
    parameter int unsigned SUPPORT_UPPER = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          id_opcode,
    input  logic                id_stall,
    input  logic                ex_flush,
    output logic                pipe_hold,
    output logic                mem_wait,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_alu_res_src,
    output logic                ex_jalr_en,
    output logic                ex_lui,
    output logic                ex_auipc,
    output logic                ex_illegal,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_branch,
    output logic                wb_mem_to_reg,
    output logic                wb_reg_write
);

    localparam int unsigned CNT_W = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                alu_res_src;
        logic                jalr_en;
        logic                lui;
        logic                auipc;
        logic                illegal;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                mem_to_reg;
        logic                reg_write;
    } idex_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic branch;
        logic mem_to_reg;
        logic reg_write;
    } exmem_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_t;

    idex_t             dec;
    idex_t             idex_d, idex_q;
    exmem_t            exmem_d, exmem_q;
    memwb_t            memwb_d, memwb_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;

    always_comb begin
        dec = '0;
        case (id_opcode)
            OP_R: begin
                dec.alu_op    = ALU_OP_W'(2'b10);
                dec.reg_write = 1'b1;
            end
            OP_I: begin
                dec.alu_op    = ALU_OP_W'(2'b11);
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            OP_S: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            OP_B: begin
                dec.alu_op = ALU_OP_W'(2'b01);
                dec.branch = 1'b1;
            end
            OP_JALR: begin
                dec.alu_res_src = 1'b1;
                dec.jalr_en     = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OP_JAL: begin
                dec.alu_res_src = 1'b1;
                dec.reg_write   = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                if (SUPPORT_UPPER != 0) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.lui       = (id_opcode == OP_LUI);
                    dec.auipc     = (id_opcode == OP_AUIPC);
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign mem_wait  = (LOAD_LAT > 1) && (cnt_q != '0);
    assign pipe_hold = id_stall | mem_wait;

    always_comb begin
        idex_d  = idex_q;
        exmem_d = exmem_q;
        memwb_d = memwb_q;
        cnt_d   = cnt_q;
        if (mem_wait) begin
            // Load still in MEM: freeze EX/MEM, drain a bubble into WB.
            memwb_d = '0;
            cnt_d   = cnt_q - CNT_W'(1);
            if (ex_flush) begin
                idex_d = '0;
            end
        end else begin
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.branch     = idex_q.branch;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.reg_write  = idex_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.reg_write  = exmem_q.reg_write;
            idex_d             = (ex_flush || id_stall) ? '0 : dec;
            if ((LOAD_LAT > 1) && idex_q.mem_read) begin
                cnt_d = CNT_W'(LOAD_LAT - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            cnt_q   <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_alu_op      = idex_q.alu_op;
    assign ex_alu_src     = idex_q.alu_src;
    assign ex_alu_res_src = idex_q.alu_res_src;
    assign ex_jalr_en     = idex_q.jalr_en;
    assign ex_lui         = idex_q.lui;
    assign ex_auipc       = idex_q.auipc;
    assign ex_illegal     = idex_q.illegal;
    assign mem_read       = exmem_q.mem_read;
    assign mem_write      = exmem_q.mem_write;
    assign mem_branch     = exmem_q.branch;
    assign wb_mem_to_reg  = memwb_q.mem_to_reg;
    assign wb_reg_write   = memwb_q.reg_write;

endmodule

// File: tb/tb_fb_cu_pipe.sv
// Bench for fb_cu_pipe: three parameterisations share stimulus and are each checked
// against an instruction-level pipeline model.
module tb_fb_cu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] id_opcode;
    logic       id_stall;
    logic       ex_flush;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LW = 7'b0000011;
    localparam logic [6:0] S = 7'b0100011, B = 7'b1100011, JALR = 7'b1100111;
    localparam logic [6:0] JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    // Instance 0: LAT 1, upper on; 1: LAT 3, upper off; 2: LAT 4, upper on, 3-bit alu_op.
    int unsigned lat_k[3] = '{1, 3, 4};
    bit          sup_k[3] = '{1'b1, 1'b0, 1'b1};

    logic [1:0] a_alu, b_alu;
    logic [2:0] c_alu;
    logic a_hold, a_wait, a_src, a_res, a_jr, a_lui, a_aui, a_ill, a_mr, a_mw, a_br, a_m2r, a_rw;
    logic b_hold, b_wait, b_src, b_res, b_jr, b_lui, b_aui, b_ill, b_mr, b_mw, b_br, b_m2r, b_rw;
    logic c_hold, c_wait, c_src, c_res, c_jr, c_lui, c_aui, c_ill, c_mr, c_mw, c_br, c_m2r, c_rw;

    fb_cu_pipe #(.ALU_OP_W(2), .LOAD_LAT(1), .SUPPORT_UPPER(1)) u_a (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_stall(id_stall), .ex_flush(ex_flush),
        .pipe_hold(a_hold), .mem_wait(a_wait), .ex_alu_op(a_alu), .ex_alu_src(a_src),
        .ex_alu_res_src(a_res), .ex_jalr_en(a_jr), .ex_lui(a_lui), .ex_auipc(a_aui),
        .ex_illegal(a_ill), .mem_read(a_mr), .mem_write(a_mw), .mem_branch(a_br),
        .wb_mem_to_reg(a_m2r), .wb_reg_write(a_rw)
    );

    fb_cu_pipe #(.ALU_OP_W(2), .LOAD_LAT(3), .SUPPORT_UPPER(0)) u_b (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_stall(id_stall), .ex_flush(ex_flush),
        .pipe_hold(b_hold), .mem_wait(b_wait), .ex_alu_op(b_alu), .ex_alu_src(b_src),
        .ex_alu_res_src(b_res), .ex_jalr_en(b_jr), .ex_lui(b_lui), .ex_auipc(b_aui),
        .ex_illegal(b_ill), .mem_read(b_mr), .mem_write(b_mw), .mem_branch(b_br),
        .wb_mem_to_reg(b_m2r), .wb_reg_write(b_rw)
    );

    fb_cu_pipe #(.ALU_OP_W(3), .LOAD_LAT(4), .SUPPORT_UPPER(1)) u_c (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_stall(id_stall), .ex_flush(ex_flush),
        .pipe_hold(c_hold), .mem_wait(c_wait), .ex_alu_op(c_alu), .ex_alu_src(c_src),
        .ex_alu_res_src(c_res), .ex_jalr_en(c_jr), .ex_lui(c_lui), .ex_auipc(c_aui),
        .ex_illegal(c_ill), .mem_read(c_mr), .mem_write(c_mw), .mem_branch(c_br),
        .wb_mem_to_reg(c_m2r), .wb_reg_write(c_rw)
    );

    logic [8:0] obs_ex[3];
    logic [2:0] obs_mem[3];
    logic [1:0] obs_wb[3];
    logic [1:0] obs_st[3];

    assign obs_ex[0]  = {1'b0, a_alu, a_src, a_res, a_jr, a_lui, a_aui, a_ill};
    assign obs_ex[1]  = {1'b0, b_alu, b_src, b_res, b_jr, b_lui, b_aui, b_ill};
    assign obs_ex[2]  = {c_alu, c_src, c_res, c_jr, c_lui, c_aui, c_ill};
    assign obs_mem[0] = {a_mr, a_mw, a_br};
    assign obs_mem[1] = {b_mr, b_mw, b_br};
    assign obs_mem[2] = {c_mr, c_mw, c_br};
    assign obs_wb[0]  = {a_m2r, a_rw};
    assign obs_wb[1]  = {b_m2r, b_rw};
    assign obs_wb[2]  = {c_m2r, c_rw};
    assign obs_st[0]  = {a_hold, a_wait};
    assign obs_st[1]  = {b_hold, b_wait};
    assign obs_st[2]  = {c_hold, c_wait};

    // Model: each stage holds an instruction (opcode + valid); controls derived on demand.
    bit [6:0] m_ex_op[3], m_mem_op[3], m_wb_op[3];
    bit       m_ex_v[3], m_mem_v[3], m_wb_v[3];
    int       m_age[3];

    // {alu_op[1:0], alu_src, res_src, jalr, lui, auipc, illegal, mr, mw, br, m2r, rw}
    function automatic logic [12:0] dec(input logic [6:0] op, input bit sup);
        logic [1:0] alu;
        logic src, res, jr, lui, aui, ill, mr, mw, br, m2r, rw;
        alu = 2'b00;
        {src, res, jr, lui, aui, ill, mr, mw, br, m2r, rw} = '0;
        case (op)
            R:     begin alu = 2'b10; rw = 1'b1; end
            I:     begin alu = 2'b11; src = 1'b1; rw = 1'b1; end
            LW:    begin src = 1'b1; mr = 1'b1; m2r = 1'b1; rw = 1'b1; end
            S:     begin src = 1'b1; mw = 1'b1; end
            B:     begin alu = 2'b01; br = 1'b1; end
            JALR:  begin res = 1'b1; jr = 1'b1; rw = 1'b1; end
            JAL:   begin res = 1'b1; rw = 1'b1; end
            LUI:   if (sup) begin src = 1'b1; rw = 1'b1; lui = 1'b1; end else ill = 1'b1;
            AUIPC: if (sup) begin src = 1'b1; rw = 1'b1; aui = 1'b1; end else ill = 1'b1;
            default: ill = 1'b1;
        endcase
        return {alu, src, res, jr, lui, aui, ill, mr, mw, br, m2r, rw};
    endfunction

    function automatic bit load_waiting(input int k);
        return m_mem_v[k] && (m_mem_op[k] == LW) && (m_age[k] < int'(lat_k[k]));
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_ex_v[k]  = 1'b0;
            m_mem_v[k] = 1'b0;
            m_wb_v[k]  = 1'b0;
            m_age[k]   = 0;
        end
    endtask

    // Drive one cycle from a negedge: check current outputs, clock, advance the model.
    task automatic step(input logic r, input logic [6:0] op, input logic st, input logic fl);
        logic [12:0] de, dm, dw;
        bit          w[3];
        rst = r; id_opcode = op; id_stall = st; ex_flush = fl;
        #1;
        for (int k = 0; k < 3; k++) begin
            de   = m_ex_v[k]  ? dec(m_ex_op[k],  sup_k[k]) : 13'd0;
            dm   = m_mem_v[k] ? dec(m_mem_op[k], sup_k[k]) : 13'd0;
            dw   = m_wb_v[k]  ? dec(m_wb_op[k],  sup_k[k]) : 13'd0;
            w[k] = load_waiting(k);
            check_eq($sformatf("ex[%0d]", k),  32'(obs_ex[k]),  32'({1'b0, de[12:5]}));
            check_eq($sformatf("mem[%0d]", k), 32'(obs_mem[k]), 32'(dm[4:2]));
            check_eq($sformatf("wb[%0d]", k),  32'(obs_wb[k]),  32'(dw[1:0]));
            check_eq($sformatf("hold_wait[%0d]", k), 32'(obs_st[k]), 32'({st | w[k], w[k]}));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_ex_v[k] = 1'b0; m_mem_v[k] = 1'b0; m_wb_v[k] = 1'b0; m_age[k] = 0;
            end else if (w[k]) begin
                m_wb_v[k] = 1'b0;
                m_age[k]++;
                if (fl) m_ex_v[k] = 1'b0;
            end else begin
                m_wb_v[k]   = m_mem_v[k];
                m_wb_op[k]  = m_mem_op[k];
                m_mem_v[k]  = m_ex_v[k];
                m_mem_op[k] = m_ex_op[k];
                m_age[k]    = 1;
                m_ex_v[k]   = !(st || fl);
                m_ex_op[k]  = op;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, R, 1'b0, 1'b0);
    endtask

    logic [6:0] pool[11] = '{R, I, LW, S, B, JALR, JAL, LUI, AUIPC, 7'b0000000, 7'b1111111};
    logic [6:0] seq_a[7] = '{R, I, LW, S, B, JALR, JAL};

    initial begin
        rst = 1'b1; id_opcode = 7'd0; id_stall = 1'b0; ex_flush = 1'b0;
        model_clear();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        step(1'b1, R, 1'b1, 1'b0);

        // Hazard-free instruction mix.
        for (int i = 0; i < 7; i++) step(1'b0, seq_a[i], 1'b0, 1'b0);
        drain(8);
        // Load-use stall after LW.
        step(1'b0, LW, 1'b0, 1'b0);
        step(1'b0, R, 1'b1, 1'b0);
        drain(8);
        // Flush while JAL in ID.
        step(1'b0, B, 1'b0, 1'b0);
        step(1'b0, JAL, 1'b0, 1'b1);
        drain(6);
        // Back-to-back loads and a flush during the wait.
        step(1'b0, LW, 1'b0, 1'b0);
        step(1'b0, LW, 1'b0, 1'b0);
        step(1'b0, R, 1'b0, 1'b0);
        step(1'b0, I, 1'b0, 1'b1);
        step(1'b0, R, 1'b1, 1'b0);
        drain(12);
        // Upper-immediate decode.
        step(1'b0, LUI, 1'b0, 1'b0);
        step(1'b0, AUIPC, 1'b0, 1'b0);
        drain(6);
        // Reset in the middle of a load wait.
        step(1'b0, LW, 1'b0, 1'b0);
        step(1'b0, R, 1'b0, 1'b0);
        step(1'b0, R, 1'b0, 1'b0);
        step(1'b1, R, 1'b0, 1'b0);
        drain(6);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 10)];
            step(($urandom_range(0, 99) < 2), op, ($urandom_range(0, 99) < 12),
                 ($urandom_range(0, 99) < 12));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_cu_pipe.md
Name: fb_cu_pipe

Overview:
- Parametrised, pipelined successor to the combinational control unit.
- Decodes the ID-stage opcode into control bits, then carries them through ID/EX, EX/MEM and MEM/WB control registers.
- Applies hazard-unit stall/flush bubbles to those registers.
- Extends the pipeline for multi-cycle loads (LOAD_LAT), which produces a hold request for the upstream PC and IF/ID.
- Adds optional LUI/AUIPC decode and an illegal-opcode flag.

Parameters:
ALU_OP_W, 2, width of alu_op fields; must be >= 2; the 2-bit codes are zero-extended.
LOAD_LAT, 1, cycles a load occupies MEM; must be >= 1; 1 means no extra wait.
SUPPORT_UPPER, 1, 1 decodes LUI (0110111) and AUIPC (0010111); 0 treats them as illegal.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
id_opcode  in  7  opcode of instruction in ID
id_stall  in  1  load-use stall from hazard unit; inserts a bubble into ID/EX
ex_flush  in  1  control-hazard flush (taken branch/jalr/jal); inserts a bubble into ID/EX
pipe_hold  out  1  combinational; = id_stall | mem_wait; PC and IF/ID hold when 1
mem_wait  out  1  combinational; 1 while a load is waiting in MEM
ex_alu_op  out  ALU_OP_W  registered ID/EX alu_op
ex_alu_src  out  1  registered; 1 selects imm as the ALU B operand
ex_alu_res_src  out  1  registered; 1 selects pc+1 (jal/jalr) as the EX result
ex_jalr_en  out  1  registered jalr indicator
ex_lui  out  1  registered LUI indicator
ex_auipc  out  1  registered AUIPC indicator
ex_illegal  out  1  registered illegal-opcode flag
mem_read  out  1  EX/MEM load
mem_write  out  1  EX/MEM store
mem_branch  out  1  EX/MEM branch
wb_mem_to_reg  out  1  MEM/WB write data selected from memory
wb_reg_write  out  1  MEM/WB register write enable

Behaviour:
Decode (combinational, from id_opcode):
- R 0110011: alu_op=10, reg_write=1.
- I-ALU 0010011: alu_op=11, alu_src=1, reg_write=1.
- LW 0000011: alu_op=00, alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
- S 0100011: alu_op=00, alu_src=1, mem_write=1.
- B 1100011: alu_op=01, branch=1.
- JALR 1100111: alu_res_src=1, jalr_en=1, reg_write=1, alu_op=00.
- JAL 1101111: alu_res_src=1, reg_write=1, alu_op=00.
- LUI/AUIPC (SUPPORT_UPPER=1): alu_op=00, alu_src=1, reg_write=1, lui or auipc=1.
- Any other opcode, including 0000000: illegal=1 and all other controls 0 (never writes regs or memory).
- Bubble: all controls 0, illegal 0.

Registers:
- ID/EX holds the ex_* outputs plus the decoded mem/wb bits internally.
- EX/MEM holds mem_read, mem_write, mem_branch plus mem_to_reg and reg_write internally.
- MEM/WB holds the wb_* outputs.

Reset:
- All registered outputs 0, wait counter 0, so mem_wait=0 and pipe_hold=id_stall.

Per-cycle update, priority order rst > mem_wait > flush/stall > advance:
- mem_wait=1:
  - EX/MEM holds.
  - MEM/WB loads a bubble.
  - ID/EX holds, unless ex_flush=1, in which case it loads a bubble.
  - id_stall is ignored; pipe_hold is already 1.
- Otherwise, if ex_flush or id_stall:
  - ID/EX loads a bubble.
  - EX/MEM loads from ID/EX.
  - MEM/WB loads from EX/MEM.
  - flush and stall together are treated as one bubble.
- Otherwise all three registers advance; ID/EX loads the decode.

Load wait counter:
- Width clog2(LOAD_LAT).
- On a cycle where EX/MEM loads an entry with mem_read=1 and LOAD_LAT>1, the counter loads LOAD_LAT-1.
- While the counter is nonzero it decrements each cycle; mem_wait = (counter != 0).
- The load reaches MEM/WB on the cycle after the counter hits 0, so a load spends exactly LOAD_LAT cycles in EX/MEM.
- Back-to-back loads each incur the full wait.
- LOAD_LAT=1: the counter is constant 0 and behaviour is a plain 3-stage control pipe.

Reset mid-wait: counter clears and the pending load is dropped (no wb_reg_write).

Latency: a decoded instruction appears at ex_* 1 cycle after ID, at mem_* after 2, and at wb_* after 3, plus LOAD_LAT-1 for loads.

Test Plan:
- Reset then id_opcode sequence R,I,LW,S,B,JALR,JAL with no hazards -> ex_alu_op 10,11,00,00,01,00,00 on cycles 1-7; wb_reg_write pattern 1,1,1,0,0,1,1 on cycles 3-9; wb_mem_to_reg 1 only for LW.
- LW then R with id_stall=1 for one cycle after LW -> one all-zero bubble visible at ex_* then mem_*; pipe_hold=1 that cycle only.
- B in EX with ex_flush=1 while JAL in ID -> ex_* all 0 next cycle; JAL never asserts wb_reg_write.
- LOAD_LAT=3, LW followed by R,R -> mem_wait=1 for 2 cycles after LW enters EX/MEM; mem_read held 3 cycles; MEM/WB carries 2 bubbles; LW wb_reg_write=1 exactly once.
- SUPPORT_UPPER=0 with opcode 0110111 -> ex_illegal=1, all other ex_* 0. SUPPORT_UPPER=1 -> ex_lui=1, ex_alu_src=1, wb_reg_write=1 three cycles later.
- rst asserted during mem_wait (LOAD_LAT=4) -> next cycle all outputs 0, mem_wait=0, no wb_reg_write for the load.
